// File: rtl/acc_trace_fifo.sv
// rtl/acc_trace_fifo.sv - accumulator-write trace FIFO for the BIP CPU
//
// Captures every accumulator write (WR_ACC strobe, updated ACC, PC of the
// writing instruction) into a circular buffer drained through a
// first-word-fall-through pop interface.
//
// Optional feature macro: ACC_TRACE_TIMESTAMP_EN adds a free-running
// timestamp counter, per-entry timestamp storage and the RD_TS port.
//
// Ports:
//   CLK, RESET       clock (rising edge), asynchronous active-high reset
//   CLR              synchronous flush of FIFO, flags, counters, pending capture
//   CAPTURE_EN       gates new captures together with WR_ACC
//   WRAP_MODE        0 = drop newest when full, 1 = overwrite oldest
//   WR_ACC, ACC, PC  capture strobe, accumulator value, program counter
//   RD               pop request (ignored when EMPTY)
//   RD_DATA, RD_PC   head entry, 0 when EMPTY
//   RD_TS            head timestamp (macro only)
//   EMPTY, FULL      registered occupancy flags
//   COUNT            registered occupancy
//   OVERFLOW         sticky lost-entry flag
//   DROP_CNT         lost-entry count, saturating at 255
module acc_trace_fifo #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 11,
  parameter int DEPTH_LOG2 = 4,
  parameter int TS_W       = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  CLR,
  input  logic                  CAPTURE_EN,
  input  logic                  WRAP_MODE,
  input  logic                  WR_ACC,
  input  logic [DATA_W-1:0]     ACC,
  input  logic [ADDR_W-1:0]     PC,
  input  logic                  RD,
  output logic [DATA_W-1:0]     RD_DATA,
  output logic [ADDR_W-1:0]     RD_PC,
`ifdef ACC_TRACE_TIMESTAMP_EN
  output logic [TS_W-1:0]       RD_TS,
`endif
  output logic                  EMPTY,
  output logic                  FULL,
  output logic [DEPTH_LOG2:0]   COUNT,
  output logic                  OVERFLOW,
  output logic [7:0]            DROP_CNT
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [DATA_W-1:0]     mem_data_q [DEPTH];
  logic [ADDR_W-1:0]     mem_pc_q   [DEPTH];

  logic                  pend_q, pend_d;
  logic [ADDR_W-1:0]     pend_pc_q, pend_pc_d;
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  ovf_q, ovf_d;
  logic [7:0]            drop_q, drop_d;
  logic                  do_write;
  logic                  push;
  logic                  pop;

  // The push happens one edge after the strobe so that ACC already carries
  // the value written by the instruction whose PC was latched.
  assign push = pend_q;
  assign pop  = RD && !empty_q;

  always_comb begin
    pend_d    = 1'b0;
    pend_pc_d = pend_pc_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    drop_d    = drop_q;
    do_write  = 1'b0;
    if (CLR) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      drop_d  = '0;
    end else begin
      pend_d = WR_ACC && CAPTURE_EN;
      if (WR_ACC && CAPTURE_EN) pend_pc_d = PC;
      if (push && pop) begin
        // Simultaneous push/pop never overflows, even when full.
        do_write = 1'b1;
        wptr_d   = wptr_q + 1'b1;
        rptr_d   = rptr_q + 1'b1;
      end else if (push && full_q) begin
        ovf_d = 1'b1;
        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        if (WRAP_MODE) begin
          // Overwrite the oldest slot: write pointer equals read pointer here.
          do_write = 1'b1;
          wptr_d   = wptr_q + 1'b1;
          rptr_d   = rptr_q + 1'b1;
        end
      end else if (push) begin
        do_write = 1'b1;
        wptr_d   = wptr_q + 1'b1;
        count_d  = count_q + 1'b1;
      end else if (pop) begin
        rptr_d  = rptr_q + 1'b1;
        count_d = count_q - 1'b1;
      end
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == DEPTH_CNT);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
      drop_q    <= '0;
    end else begin
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
      drop_q    <= drop_d;
    end
  end

  // Storage is not reset; do_write is low while RESET holds pend_q at 0.
  always_ff @(posedge CLK) begin
    if (do_write) begin
      mem_data_q[wptr_q] <= ACC;
      mem_pc_q[wptr_q]   <= pend_pc_q;
    end
  end

`ifdef ACC_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] mem_ts_q [DEPTH];
  logic [TS_W-1:0] ts_q;

  // Free-running; deliberately untouched by CLR.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) ts_q <= '0;
    else       ts_q <= ts_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (do_write) mem_ts_q[wptr_q] <= ts_q;
  end

  assign RD_TS = empty_q ? '0 : mem_ts_q[rptr_q];
`endif

  assign RD_DATA  = empty_q ? '0 : mem_data_q[rptr_q];
  assign RD_PC    = empty_q ? '0 : mem_pc_q[rptr_q];
  assign EMPTY    = empty_q;
  assign FULL     = full_q;
  assign COUNT    = count_q;
  assign OVERFLOW = ovf_q;
  assign DROP_CNT = drop_q;

endmodule

// File: tb/tb_acc_trace_fifo.sv
// tb/tb_acc_trace_fifo.sv - scoreboard bench for acc_trace_fifo
module tb_acc_trace_fifo;
  localparam int DW = 16, AW = 11, DL = 4, TW = 16;
  localparam int DEPTH = 1 << DL;

  logic CLK = 1'b0, RESET = 1'b1, CLR = 1'b0, CAPTURE_EN = 1'b0;
  logic WRAP_MODE = 1'b0, WR_ACC = 1'b0, RD = 1'b0;
  logic [DW-1:0] ACC = '0;
  logic [AW-1:0] PC = '0;
  logic [DW-1:0] RD_DATA;
  logic [AW-1:0] RD_PC;
  logic [TW-1:0] RD_TS;
  logic EMPTY, FULL, OVERFLOW;
  logic [DL:0] COUNT;
  logic [7:0] DROP_CNT;

  acc_trace_fifo #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_LOG2(DL), .TS_W(TW)) dut (
    .CLK(CLK), .RESET(RESET), .CLR(CLR), .CAPTURE_EN(CAPTURE_EN),
    .WRAP_MODE(WRAP_MODE), .WR_ACC(WR_ACC), .ACC(ACC), .PC(PC), .RD(RD),
    .RD_DATA(RD_DATA), .RD_PC(RD_PC),
`ifdef ACC_TRACE_TIMESTAMP_EN
    .RD_TS(RD_TS),
`endif
    .EMPTY(EMPTY), .FULL(FULL), .COUNT(COUNT), .OVERFLOW(OVERFLOW),
    .DROP_CNT(DROP_CNT)
  );

`ifndef ACC_TRACE_TIMESTAMP_EN
  assign RD_TS = '0;
`endif

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [TW-1:0] ts;
    logic [DW-1:0] d;
    logic [AW-1:0] pc;
  } ent_t;

  ent_t model_q[$];
  ent_t exp_q[$];
  logic m_pend = 1'b0;
  logic [AW-1:0] m_pend_pc = '0;
  logic m_ovf = 1'b0;
  int m_drop = 0;
  logic [TW-1:0] m_ts = '0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted pop is compared against the scoreboard.
  always @(negedge CLK) begin
    if (!RESET && RD && !EMPTY && !CLR) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected actual=%0h expected=none at %0t", RD_DATA, $time);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        chk("pop_data", RD_DATA, e.d);
        chk("pop_pc", RD_PC, e.pc);
`ifdef ACC_TRACE_TIMESTAMP_EN
        chk("pop_ts", RD_TS, e.ts);
`endif
      end
    end
  end

  // Drive one cycle, advance the reference queue model, then check flags.
  task automatic step(input logic wr, input logic en, input logic wrap, input logic rd,
                      input logic clr, input logic [DW-1:0] acc, input logic [AW-1:0] pc);
    ent_t e;
    WR_ACC = wr; CAPTURE_EN = en; WRAP_MODE = wrap; RD = rd; CLR = clr; ACC = acc; PC = pc;
    if (clr) begin
      model_q.delete();
      m_ovf = 1'b0; m_drop = 0; m_pend = 1'b0;
    end else begin
      if (m_pend) begin
        e.ts = m_ts; e.d = acc; e.pc = m_pend_pc;
        if (rd && model_q.size() > 0) begin
          exp_q.push_back(model_q.pop_front());
          model_q.push_back(e);
        end else if (model_q.size() == DEPTH) begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
          if (wrap) begin
            void'(model_q.pop_front());
            model_q.push_back(e);
          end
        end else begin
          model_q.push_back(e);
        end
      end else if (rd && model_q.size() > 0) begin
        exp_q.push_back(model_q.pop_front());
      end
      m_pend = wr && en;
      if (wr && en) m_pend_pc = pc;
    end
    m_ts = m_ts + 1'b1;
    @(posedge CLK); #1;
    chk("count", COUNT, model_q.size());
    chk("empty", EMPTY, model_q.size() == 0);
    chk("full", FULL, model_q.size() == DEPTH);
    chk("overflow", OVERFLOW, m_ovf);
    chk("drop_cnt", DROP_CNT, m_drop);
    if (model_q.size() == 0) chk("rd_data_empty", RD_DATA, 0);
  endtask

  task automatic fill(input int n, input logic wrap);
    for (int k = 1; k <= n + 1; k++)
      step(k <= n, 1'b1, wrap, 1'b0, 1'b0, DW'(k - 1), AW'(k));
  endtask

  task automatic drain(input logic wrap);
    for (int k = 0; k < DEPTH + 2; k++) step(1'b0, 1'b1, wrap, 1'b1, 1'b0, '0, '0);
  endtask

  task automatic clear();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_empty", EMPTY, 1);
    chk("rst_full", FULL, 0);
    chk("rst_count", COUNT, 0);
    chk("rst_ovf", OVERFLOW, 0);
    chk("rst_drop", DROP_CNT, 0);
    chk("rst_data", RD_DATA, 0);
    chk("rst_pc", RD_PC, 0);
    chk("rst_ts", RD_TS, 0);
    RESET = 1'b0;

    // Single capture: strobe, then ACC carries the written value.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 11'h005);
    chk("t1_empty_after_1", EMPTY, 1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 11'h000);
    chk("t1_count", COUNT, 1);
    chk("t1_data", RD_DATA, 16'h1234);
    chk("t1_pc", RD_PC, 11'h005);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0, '0);
    chk("t1_empty_after_pop", EMPTY, 1);

    // Stop-on-full: 19 strobes keep 1..16.
    clear();
    fill(19, 1'b0);
    chk("t2_full", FULL, 1);
    chk("t2_ovf", OVERFLOW, 1);
    chk("t2_drop", DROP_CNT, 3);
    chk("t2_head", RD_DATA, 1);
    drain(1'b0);

    // Overwrite-oldest: 19 strobes keep 4..19.
    clear();
    fill(19, 1'b1);
    chk("t3_drop", DROP_CNT, 3);
    chk("t3_head", RD_DATA, 4);
    drain(1'b1);

    // Full FIFO with push and pop on the same edge.
    clear();
    fill(16, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, 11'h7AA);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd99, '0);
    chk("t4_count", COUNT, 16);
    chk("t4_ovf", OVERFLOW, 0);
    chk("t4_head", RD_DATA, 2);
    drain(1'b0);

    // CLR coincident with a pending push.
    clear();
    fill(5, 1'b0);
    chk("t5_count_before", COUNT, 5);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, 11'h055);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'hBEEF, '0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    chk("t5_count", COUNT, 0);
    chk("t5_empty", EMPTY, 1);
    chk("t5_drop", DROP_CNT, 0);

    // Captures disabled.
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, DW'(k), AW'(k));
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    chk("t6_count", COUNT, 0);

    // Strobes ten cycles apart (timestamps differ by 10 with the macro).
    for (int s = 0; s < 3; s++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, AW'(s));
      for (int k = 0; k < 9; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, DW'(100 + s), '0);
    end
    drain(1'b0);

    // Randomised traffic: low pop rate first to reach full, then higher.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
           (n < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0),
           $urandom_range(0, 149) == 0, DW'($urandom), AW'($urandom));
    end
    drain(1'b0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
